// File: rtl/obj_pkg.sv
// Shared types for the obstacle-detection scan front end: scan states, channel indices, emitter encoding.
// SCAN_FRONT_PRIORITY_EN selects the four-slot L-F-R-F scan order instead of L-R-F.
package obj_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      GUARD  = 2'd3
   } scan_state_t;

   localparam logic [1:0] CH_L = 2'd0;
   localparam logic [1:0] CH_R = 2'd1;
   localparam logic [1:0] CH_F = 2'd2;

   localparam logic [2:0] EMIT_OFF = 3'b000;
   localparam logic [2:0] EMIT_L   = 3'b001;
   localparam logic [2:0] EMIT_R   = 3'b010;
   localparam logic [2:0] EMIT_F   = 3'b100;

   localparam int SLOT_W = 2;
`ifdef SCAN_FRONT_PRIORITY_EN
   localparam int N_SLOTS = 4;
`else
   localparam int N_SLOTS = 3;
`endif

   // Maps a slot position within one scan to the channel fired in that slot.
   function automatic logic [1:0] slot_channel(input logic [SLOT_W-1:0] slot);
`ifdef SCAN_FRONT_PRIORITY_EN
      case (slot)
         2'd0:    slot_channel = CH_L;
         2'd1:    slot_channel = CH_F;
         2'd2:    slot_channel = CH_R;
         default: slot_channel = CH_F;
      endcase
`else
      case (slot)
         2'd0:    slot_channel = CH_L;
         2'd1:    slot_channel = CH_R;
         default: slot_channel = CH_F;
      endcase
`endif
   endfunction

   function automatic logic [2:0] emit_onehot(input logic [1:0] ch);
      case (ch)
         CH_L:    emit_onehot = EMIT_L;
         CH_R:    emit_onehot = EMIT_R;
         CH_F:    emit_onehot = EMIT_F;
         default: emit_onehot = EMIT_OFF;
      endcase
   endfunction

endpackage

// File: rtl/scan_debounce.sv
// One channel's hit debouncer: the level flips only after DEBOUNCE_N consecutive
// disagreeing raw samples; a single agreeing sample clears the run.
module scan_debounce #(
   parameter int DEBOUNCE_N = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_upd,
   input  logic i_raw,
   output logic o_level
);

   localparam int CNT_W = (DEBOUNCE_N < 1) ? 1 : $clog2(DEBOUNCE_N + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (i_upd) begin
         if (i_raw == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/sensor_scan_sched.sv
// Time-multiplexed emitter scan scheduler: fires one emitter per slot, counts echo hits
// over a sample window and feeds per-channel debouncers. Optional macro: SCAN_FRONT_PRIORITY_EN.
module sensor_scan_sched
   import obj_pkg::*;
#(
   parameter int SETTLE_CYC = 8,
   parameter int SAMPLE_CYC = 4,
   parameter int HIT_MIN    = 3,
   parameter int DEBOUNCE_N = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       echo,
   output logic [2:0] emit_sel,
   output logic       L,
   output logic       R,
   output logic       F,
   output logic       scan_done
);

   localparam int HIT_W   = $clog2(SAMPLE_CYC + 1);
   localparam int CYC_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
   localparam int CYC_W   = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);

   localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
   localparam logic [CYC_W-1:0]  SAMPLE_LAST = CYC_W'(SAMPLE_CYC - 1);
   localparam logic [HIT_W-1:0]  HIT_SAT     = HIT_W'(SAMPLE_CYC);
   localparam logic [HIT_W-1:0]  HIT_THR     = HIT_W'(HIT_MIN);
   localparam logic [SLOT_W-1:0] FIRST_SLOT  = '0;
   localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(N_SLOTS - 1);

   scan_state_t       r_state;
   logic [SLOT_W-1:0] r_slot;
   logic [CYC_W-1:0]  r_cyc;
   logic [HIT_W-1:0]  r_hits;
   logic [2:0]        r_emit;
   logic              r_done;

   logic [HIT_W-1:0]  w_hits_next;
   logic [SLOT_W-1:0] w_slot_next;
   logic [1:0]        w_ch;
   logic              w_sample_end;
   logic              w_raw_hit;
   logic [2:0]        w_upd;

   // The final SAMPLE cycle's echo must count toward the hit decision taken on the same edge.
   always_comb begin
      w_ch         = slot_channel(r_slot);
      w_slot_next  = r_slot + SLOT_W'(1);
      w_hits_next  = r_hits;
      if (echo && (r_hits != HIT_SAT)) begin
         w_hits_next = r_hits + HIT_W'(1);
      end
      w_sample_end = (r_state == SAMPLE) && (r_cyc == SAMPLE_LAST);
      w_raw_hit    = (w_hits_next >= HIT_THR);
      w_upd        = w_sample_end ? emit_onehot(w_ch) : 3'b000;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_slot  <= '0;
         r_cyc   <= '0;
         r_hits  <= '0;
         r_emit  <= EMIT_OFF;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state <= SETTLE;
                  r_slot  <= FIRST_SLOT;
                  r_cyc   <= '0;
                  r_hits  <= '0;
                  r_emit  <= emit_onehot(slot_channel(FIRST_SLOT));
               end
            end
            SETTLE: begin
               if (r_cyc == SETTLE_LAST) begin
                  r_state <= SAMPLE;
                  r_cyc   <= '0;
                  r_hits  <= '0;
               end else begin
                  r_cyc <= r_cyc + CYC_W'(1);
               end
            end
            SAMPLE: begin
               r_hits <= w_hits_next;
               if (r_cyc == SAMPLE_LAST) begin
                  r_state <= GUARD;
                  r_cyc   <= '0;
                  r_emit  <= EMIT_OFF;
                  r_done  <= (r_slot == LAST_SLOT);
               end else begin
                  r_cyc <= r_cyc + CYC_W'(1);
               end
            end
            GUARD: begin
               r_cyc  <= '0;
               r_hits <= '0;
               // enable is only consulted at the scan boundary, so a drop never aborts a scan.
               if (r_slot != LAST_SLOT) begin
                  r_state <= SETTLE;
                  r_slot  <= w_slot_next;
                  r_emit  <= emit_onehot(slot_channel(w_slot_next));
               end else if (enable) begin
                  r_state <= SETTLE;
                  r_slot  <= FIRST_SLOT;
                  r_emit  <= emit_onehot(slot_channel(FIRST_SLOT));
               end else begin
                  r_state <= IDLE;
                  r_slot  <= FIRST_SLOT;
               end
            end
            default: begin
               r_state <= IDLE;
               r_emit  <= EMIT_OFF;
            end
         endcase
      end
   end

   scan_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb_l (
      .clk     (clk),
      .reset   (reset),
      .i_upd   (w_upd[CH_L]),
      .i_raw   (w_raw_hit),
      .o_level (L)
   );

   scan_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb_r (
      .clk     (clk),
      .reset   (reset),
      .i_upd   (w_upd[CH_R]),
      .i_raw   (w_raw_hit),
      .o_level (R)
   );

   scan_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb_f (
      .clk     (clk),
      .reset   (reset),
      .i_upd   (w_upd[CH_F]),
      .i_raw   (w_raw_hit),
      .o_level (F)
   );

   assign emit_sel  = r_emit;
   assign scan_done = r_done;

endmodule

// File: tb/tb_sensor_scan_sched.sv
// Bench for sensor_scan_sched: slot-position reference model plus directed echo patterns.
module tb_sensor_scan_sched;

   localparam int S  = 8;
   localparam int W  = 4;
   localparam int HM = 3;
   localparam int DN = 2;
   localparam int GP = S + W;
`ifdef SCAN_FRONT_PRIORITY_EN
   localparam int NS = 4;
`else
   localparam int NS = 3;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       echo = 1'b0;
   logic [2:0] emit_sel;
   logic       L, R, F;
   logic       scan_done;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   logic [3:0] mask [3];

   bit m_active = 1'b0;
   int m_pos = 0, m_slot = 0, m_hits = 0;
   int m_cnt [3];
   bit m_lvl [3];

   sensor_scan_sched #(
      .SETTLE_CYC (S),
      .SAMPLE_CYC (W),
      .HIT_MIN    (HM),
      .DEBOUNCE_N (DN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .echo      (echo),
      .emit_sel  (emit_sel),
      .L         (L),
      .R         (R),
      .F         (F),
      .scan_done (scan_done)
   );

   always #5 clk = ~clk;

   function automatic int ch_of(input int slot);
`ifdef SCAN_FRONT_PRIORITY_EN
      int order [4] = '{0, 2, 1, 2};
`else
      int order [4] = '{0, 1, 2, 2};
`endif
      return order[slot];
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: the scan is a sequence of slots of GP+1 cycles each.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active = 1'b0;
         m_pos = 0; m_slot = 0; m_hits = 0;
         for (int c = 0; c < 3; c++) begin m_cnt[c] = 0; m_lvl[c] = 1'b0; end
      end else if (!m_active) begin
         if (enable) begin m_active = 1'b1; m_pos = 0; m_slot = 0; m_hits = 0; end
      end else if (m_pos < GP) begin
         if (m_pos >= S && echo) m_hits++;
         if (m_pos == GP - 1) begin
            int c;
            bit hit;
            c = ch_of(m_slot);
            hit = (m_hits >= HM);
            if (hit == m_lvl[c]) m_cnt[c] = 0;
            else begin
               m_cnt[c]++;
               if (m_cnt[c] == DN) begin m_lvl[c] = ~m_lvl[c]; m_cnt[c] = 0; end
            end
         end
         m_pos++;
      end else begin
         if (m_slot < NS - 1) begin m_slot++; m_pos = 0; m_hits = 0; end
         else if (enable) begin m_slot = 0; m_pos = 0; m_hits = 0; end
         else m_active = 1'b0;
      end
   end

   // Compare every cycle, then drive echo for the cycle in progress from the channel's mask.
   always @(negedge clk) begin
      logic [2:0] exp_emit;
      logic       exp_done;
      if (cmp_en) begin
         exp_emit = (m_active && m_pos < GP) ? (3'b001 << ch_of(m_slot)) : 3'b000;
         exp_done = m_active && (m_pos == GP) && (m_slot == NS - 1);
         check("model_outputs", {25'd0, emit_sel, scan_done, L, R, F},
               {25'd0, exp_emit, exp_done, m_lvl[0], m_lvl[1], m_lvl[2]});
      end
      if (m_active && m_pos >= S && m_pos < GP) echo = mask[ch_of(m_slot)][m_pos - S];
      else echo = 1'b0;
   end

   task automatic wait_done();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (scan_done === 1'b1) break;
      end
      if (k == 200) check("scan_done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int pulses;
      int emit_on;
      for (int c = 0; c < 3; c++) mask[c] = 4'b0000;

      #1 reset = 1'b1;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {27'd0, emit_sel, scan_done, L, R, F}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      enable = 1'b1;

      // First scan with echo low: walk the emitter sequence cycle by cycle.
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1)  check("emit_c1",  emit_sel, 3'b001);
         if (k == 12) check("emit_c12", emit_sel, 3'b001);
         if (k == 13) check("emit_c13_guard", emit_sel, 3'b000);
`ifdef SCAN_FRONT_PRIORITY_EN
         if (k == 14) check("emit_c14", emit_sel, 3'b100);
         if (k == 27) check("emit_c27", emit_sel, 3'b010);
         if (k == 39) check("done_c39", scan_done, 1'b0);
         if (k == 40) check("emit_c40", emit_sel, 3'b100);
`else
         if (k == 14) check("emit_c14", emit_sel, 3'b010);
         if (k == 26) check("emit_c26_guard", emit_sel, 3'b000);
         if (k == 27) check("emit_c27", emit_sel, 3'b100);
         if (k == 38) check("done_c38", scan_done, 1'b0);
         if (k == 39) check("done_c39", scan_done, 1'b1);
         if (k == 40) check("emit_c40_next_scan", emit_sel, 3'b001);
         if (k == 40) check("done_c40", scan_done, 1'b0);
`endif
         if (k == 39) check("lrf_zero_c39", {L, R, F}, 3'b000);
      end

`ifdef SCAN_FRONT_PRIORITY_EN
      // Finish scan 1 and measure the 52-cycle scan_done period.
      wait_done();
      for (int k = 1; k <= 52; k++) begin
         @(negedge clk);
         if (k == 51) check("prio_done_c51", scan_done, 1'b0);
         if (k == 52) check("prio_done_period52", scan_done, 1'b1);
      end
`endif

      // L echo on two consecutive scans.
      mask[0] = 4'b1111;
      wait_done();
      check("l_after_one_scan", L, 1'b0);
      wait_done();
      check("l_after_two_scans", {L, R, F}, 3'b100);

      // Alternating miss/hit must not drop L; two misses in a row must.
      mask[0] = 4'b0000; wait_done(); check("l_hold_miss1", L, 1'b1);
      mask[0] = 4'b1111; wait_done(); check("l_hold_hit1",  L, 1'b1);
      mask[0] = 4'b0000; wait_done(); check("l_hold_miss2", L, 1'b1);
      mask[0] = 4'b1111; wait_done(); check("l_hold_hit2",  L, 1'b1);
      mask[0] = 4'b0000; wait_done(); check("l_miss_a",     L, 1'b1);
      wait_done(); check("l_drop_after_two_misses", L, 1'b0);

      // Two of four F samples is below HIT_MIN.
      mask[2] = 4'b0101;
      for (int s = 0; s < 3; s++) begin
         wait_done();
         check("f_below_thresh", F, 1'b0);
      end
      mask[2] = 4'b0111;
      wait_done();
`ifdef SCAN_FRONT_PRIORITY_EN
      check("f_prio_one_scan", F, 1'b1);
`else
      check("f_one_scan", F, 1'b0);
`endif
      wait_done();
      check("f_two_scans", {L, R, F}, 3'b001);

      // Drop enable during the second slot: scan completes, then idle.
      repeat (16) @(negedge clk);
      enable = 1'b0;
      wait_done();
      pulses = 0;
      emit_on = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (scan_done) pulses++;
         if (emit_sel != 3'b000) emit_on++;
      end
      check("idle_no_extra_done", pulses, 0);
      check("idle_emit_off", emit_on, 0);
      check("idle_holds_levels", {L, R, F}, 3'b001);

      // Restart and hit reset in the middle of the L sample window.
      enable = 1'b1;
      mask[0] = 4'b1111;
      repeat (10) @(negedge clk);
      check("pre_reset_emit", emit_sel, 3'b001);
      #2 reset = 1'b1;
      #1 check("async_reset_outputs", {27'd0, emit_sel, scan_done, L, R, F}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
